// File: rtl/ac_motor_triangle_gen.sv
// ac_motor_triangle_gen: multi-channel phase-shifted triangle carrier for the PWM comparators.
// Shadowed half-period and per-channel phase offsets are applied at the trough,
// with peak/trough sync pulses and a lock flag.
// Optional macro AC_MOTOR_TRIANGLE_SYNC_EN adds the sync_in trough-forcing input.
module ac_motor_triangle_gen #(
    parameter int unsigned WIDTH     = 24,
    parameter int unsigned PERIOD_W  = 12,
    parameter int unsigned CHANNELS  = 3,
    parameter int unsigned P_DEFAULT = 1000
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               enable,
    input  logic [PERIOD_W-1:0]                period_in,
    input  logic [CHANNELS*(PERIOD_W+2)-1:0]   phase_in,
    input  logic                               period_load,
`ifdef AC_MOTOR_TRIANGLE_SYNC_EN
    input  logic                               sync_in,
`endif
    output logic [CHANNELS*WIDTH-1:0]          triangle,
    output logic                               top,
    output logic                               bottom,
    output logic                               lock
);

    localparam int unsigned PW = PERIOD_W + 2;  // position / offset width
    localparam int unsigned SW = PERIOD_W + 3;  // position + offset sum width
    localparam int unsigned CW = PERIOD_W + 4;  // signed sample compute width

    logic [PW-1:0]                    pos;
    logic [PERIOD_W-1:0]              p_act;
    logic [CHANNELS-1:0][PW-1:0]      off;
    logic [PERIOD_W-1:0]              sh_p;
    logic [CHANNELS*PW-1:0]           sh_ph;
    logic                             pending;

    logic [PW-1:0]                    four_p_c;
    logic                             p_zero_c;
    logic                             at_end_c;
    logic                             sync_c;
    logic                             wrap_c;
    logic                             apply_c;
    logic [CHANNELS-1:0][PW-1:0]      ph_c;
    logic [CHANNELS-1:0][WIDTH-1:0]   samp_c;
    logic [CHANNELS-1:0][PW-1:0]      off_nx_c;
    logic [PW-1:0]                    pos_nx_c;
    logic [CHANNELS*WIDTH-1:0]        tri_nx_c;
    logic                             top_nx_c;
    logic                             bottom_nx_c;
    logic                             lock_nx_c;

`ifdef AC_MOTOR_TRIANGLE_SYNC_EN
    assign sync_c = sync_in;
`else
    assign sync_c = 1'b0;
`endif

    // Trough / apply event decode
    always_comb begin
        four_p_c = {p_act, 2'b00};
        p_zero_c = (p_act == '0);
        at_end_c = (pos == four_p_c - PW'(1));
        wrap_c   = enable && !p_zero_c && (at_end_c || sync_c);
        apply_c  = pending && !period_load && (p_zero_c || !enable || wrap_c);
    end

    // Per-channel phase and triangle sample mapping
    always_comb begin : phase_map
        logic [SW-1:0]        sum;
        logic signed [CW-1:0] pv;
        logic signed [CW-1:0] pp;
        logic signed [CW-1:0] val;
        ph_c   = '0;
        samp_c = '0;
        sum    = '0;
        pv     = '0;
        pp     = '0;
        val    = '0;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            sum = SW'(pos) + SW'(off[k]);
            if (sum >= SW'(four_p_c)) begin
                sum = sum - SW'(four_p_c);
            end
            ph_c[k] = PW'(sum);
            pv = signed'(CW'(ph_c[k]));
            pp = signed'(CW'(p_act));
            if (ph_c[k] < PW'({p_act, 1'b0})) begin
                val = pv - pp;
            end else begin
                val = (pp + pp + pp) - pv;
            end
            samp_c[k] = p_zero_c ? '0 : WIDTH'(val);
        end
    end

    // Shadow offsets, clamped against the incoming half-period
    always_comb begin
        off_nx_c = '0;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            if (sh_ph[k*PW +: PW] >= {sh_p, 2'b00}) begin
                off_nx_c[k] = '0;
            end else begin
                off_nx_c[k] = sh_ph[k*PW +: PW];
            end
        end
    end

    // Next position, output samples, sync pulses and lock
    always_comb begin
        pos_nx_c    = pos;
        tri_nx_c    = triangle;
        top_nx_c    = 1'b0;
        bottom_nx_c = 1'b0;
        lock_nx_c   = lock;

        if (apply_c || p_zero_c) begin
            pos_nx_c = '0;
        end else if (enable) begin
            pos_nx_c = wrap_c ? '0 : pos + PW'(1);
        end

        if (p_zero_c) begin
            tri_nx_c = '0;
        end else if (enable) begin
            tri_nx_c    = samp_c;
            top_nx_c    = (ph_c[0] == PW'({p_act, 1'b0}));
            bottom_nx_c = (ph_c[0] == '0);
        end

        if (period_load || p_zero_c) begin
            lock_nx_c = 1'b0;
        end else if (wrap_c) begin
            if (!at_end_c) begin
                lock_nx_c = 1'b0;
            end else if (!pending) begin
                lock_nx_c = 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos      <= '0;
            p_act    <= PERIOD_W'(P_DEFAULT);
            off      <= '0;
            sh_p     <= '0;
            sh_ph    <= '0;
            pending  <= 1'b0;
            triangle <= '0;
            top      <= 1'b0;
            bottom   <= 1'b0;
            lock     <= 1'b0;
        end else begin
            if (period_load) begin
                sh_p    <= period_in;
                sh_ph   <= phase_in;
                pending <= 1'b1;
            end else if (apply_c) begin
                pending <= 1'b0;
            end
            if (apply_c) begin
                p_act <= sh_p;
                off   <= off_nx_c;
            end
            pos      <= pos_nx_c;
            triangle <= tri_nx_c;
            top      <= top_nx_c;
            bottom   <= bottom_nx_c;
            lock     <= lock_nx_c;
        end
    end

endmodule

// File: tb/tb_ac_motor_triangle_gen.sv
// Directed self-checking bench for ac_motor_triangle_gen (P_DEFAULT=4, 3 channels).
module tb_ac_motor_triangle_gen;

    localparam int unsigned WIDTH    = 10;
    localparam int unsigned PERIOD_W = 6;
    localparam int unsigned CHANNELS = 3;
    localparam int unsigned PHW      = PERIOD_W + 2;

    logic                         clk = 1'b0;
    logic                         reset_n;
    logic                         enable;
    logic [PERIOD_W-1:0]          period_in;
    logic [CHANNELS*PHW-1:0]      phase_in;
    logic                         period_load;
`ifdef AC_MOTOR_TRIANGLE_SYNC_EN
    logic                         sync_in = 1'b0;
`endif
    logic [CHANNELS*WIDTH-1:0]    triangle;
    logic                         top;
    logic                         bottom;
    logic                         lock;

    int checks = 0;
    int errors = 0;
    // One P=4 period, indexed by position
    int exp16[16] = '{-4, -3, -2, -1, 0, 1, 2, 3, 4, 3, 2, 1, 0, -1, -2, -3};

    ac_motor_triangle_gen #(
        .WIDTH(WIDTH), .PERIOD_W(PERIOD_W), .CHANNELS(CHANNELS), .P_DEFAULT(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .period_in(period_in),
        .phase_in(phase_in),
        .period_load(period_load),
`ifdef AC_MOTOR_TRIANGLE_SYNC_EN
        .sync_in(sync_in),
`endif
        .triangle(triangle),
        .top(top),
        .bottom(bottom),
        .lock(lock)
    );

    always #5 clk = ~clk;

    function automatic int ch(input int k);
        return int'($signed(triangle[k*WIDTH +: WIDTH]));
    endfunction

    // Triangle value at position p for half-period pp
    function automatic int tri_ref(input int p, input int pp);
        return (p < 2 * pp) ? p - pp : 3 * pp - p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; period_load = 1'b0;
        period_in = '0; phase_in = '0;
        repeat (2) step();
        checks++;
        if (triangle !== '0 || top !== 1'b0 || bottom !== 1'b0 || lock !== 1'b0) begin
            errors++;
            $display("FAIL reset got tri=%h top=%b bot=%b lock=%b exp all zero", triangle, top, bottom, lock);
        end
    endtask

    task automatic test_basic();
        int e;
        reset_n = 1'b1; enable = 1'b1;
        for (int k = 0; k < 32; k++) begin
            step();
            e = exp16[k % 16];
            for (int c = 0; c < int'(CHANNELS); c++) begin
                checks++;
                if (ch(c) !== e) begin errors++; $display("FAIL basic ch%0d k=%0d got %0d exp %0d", c, k, ch(c), e); end
            end
            checks++;
            if (top !== (k % 16 == 8) || bottom !== (k % 16 == 0) || lock !== (k >= 15)) begin
                errors++;
                $display("FAIL basic_flags k=%0d got top=%b bot=%b lock=%b exp %b %b %b",
                         k, top, bottom, lock, (k % 16 == 8), (k % 16 == 0), (k >= 15));
            end
        end
    endtask

    task automatic test_phase();
        period_in = 6'd4; phase_in = {8'd11, 8'd5, 8'd0}; period_load = 1'b1;
        step();
        period_load = 1'b0;
        checks++;
        if (ch(0) !== -4 || lock !== 1'b0) begin errors++; $display("FAIL phase_load got ch0=%0d lock=%b exp -4 0", ch(0), lock); end
        repeat (15) step();
        checks++;
        if (ch(1) !== -3 || lock !== 1'b0) begin errors++; $display("FAIL phase_early got ch1=%0d lock=%b exp -3 0", ch(1), lock); end
        step();
        checks++;
        if (ch(0) !== -4 || ch(1) !== 1 || ch(2) !== 1 || bottom !== 1'b1) begin
            errors++;
            $display("FAIL phase_apply got %0d %0d %0d bot=%b exp -4 1 1 1", ch(0), ch(1), ch(2), bottom);
        end
        for (int k = 1; k < 16; k++) begin
            step();
            checks++;
            if (ch(0) !== exp16[k] || ch(1) !== exp16[(k+5)%16] || ch(2) !== exp16[(k+11)%16] || lock !== (k == 15)) begin
                errors++;
                $display("FAIL phase_run k=%0d got %0d %0d %0d lock=%b exp %0d %0d %0d %b", k, ch(0), ch(1), ch(2), lock,
                         exp16[k], exp16[(k+5)%16], exp16[(k+11)%16], (k == 15));
            end
        end
    endtask

    task automatic test_freeze();
        repeat (8) step();
        checks++;
        if (ch(0) !== 3) begin errors++; $display("FAIL freeze_pre got %0d exp 3", ch(0)); end
        enable = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            checks++;
            if (ch(0) !== 3 || ch(1) !== 0 || ch(2) !== -2 || top !== 1'b0 || bottom !== 1'b0 || lock !== 1'b1) begin
                errors++;
                $display("FAIL freeze i=%0d got %0d %0d %0d top=%b bot=%b lock=%b exp 3 0 -2 0 0 1",
                         i, ch(0), ch(1), ch(2), top, bottom, lock);
            end
        end
        enable = 1'b1;
        step();
        checks++;
        if (ch(0) !== 4 || top !== 1'b1 || ch(1) !== -1 || ch(2) !== -1) begin
            errors++;
            $display("FAIL freeze_resume got %0d %0d %0d top=%b exp 4 -1 -1 1", ch(0), ch(1), ch(2), top);
        end
    endtask

    task automatic test_period_change();
        int e;
        repeat (2) step();
        checks++;
        if (ch(0) !== 2) begin errors++; $display("FAIL chg_pre got %0d exp 2", ch(0)); end
        period_in = 6'd6; phase_in = '0; period_load = 1'b1;
        step();
        period_load = 1'b0;
        checks++;
        if (ch(0) !== 1 || lock !== 1'b0) begin errors++; $display("FAIL chg_load got %0d lock=%b exp 1 0", ch(0), lock); end
        for (int p = 12; p < 16; p++) begin
            step();
            checks++;
            if (ch(0) !== exp16[p] || lock !== 1'b0) begin
                errors++; $display("FAIL chg_tail p=%0d got %0d lock=%b exp %0d 0", p, ch(0), lock, exp16[p]);
            end
        end
        for (int k = 0; k < 24; k++) begin
            step();
            e = tri_ref(k, 6);
            checks++;
            if (ch(0) !== e || ch(1) !== e || ch(2) !== e || top !== (k == 12) || bottom !== (k == 0) || lock !== (k == 23)) begin
                errors++;
                $display("FAIL chg_run k=%0d got %0d %0d %0d top=%b bot=%b lock=%b exp %0d %b %b %b", k, ch(0), ch(1), ch(2),
                         top, bottom, lock, e, (k == 12), (k == 0), (k == 23));
            end
        end
    endtask

    task automatic test_zero_period();
        period_in = '0; phase_in = '0; period_load = 1'b1;
        step();
        period_load = 1'b0;
        checks++;
        if (ch(0) !== -6 || lock !== 1'b0) begin errors++; $display("FAIL zero_load got %0d lock=%b exp -6 0", ch(0), lock); end
        repeat (23) step();
        checks++;
        if (ch(0) !== -5) begin errors++; $display("FAIL zero_tail got %0d exp -5", ch(0)); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (triangle !== '0 || top !== 1'b0 || bottom !== 1'b0 || lock !== 1'b0) begin
                errors++; $display("FAIL zero_hold i=%0d got tri=%h top=%b bot=%b lock=%b exp zero", i, triangle, top, bottom, lock);
            end
        end
        period_in = 6'd3; phase_in = {8'd12, 8'd2, 8'd0}; period_load = 1'b1;
        step();
        period_load = 1'b0;
        checks++;
        if (triangle !== '0 || lock !== 1'b0) begin errors++; $display("FAIL p3_load got tri=%h lock=%b exp 0 0", triangle, lock); end
        step();
        checks++;
        if (triangle !== '0) begin errors++; $display("FAIL p3_apply got tri=%h exp 0", triangle); end
        for (int k = 0; k < 12; k++) begin
            step();
            checks++;
            if (ch(0) !== tri_ref(k, 3) || ch(1) !== tri_ref((k + 2) % 12, 3) || ch(2) !== tri_ref(k, 3) ||
                top !== (k == 6) || bottom !== (k == 0) || lock !== (k == 11)) begin
                errors++;
                $display("FAIL p3_run k=%0d got %0d %0d %0d top=%b bot=%b lock=%b exp %0d %0d %0d %b %b %b", k, ch(0), ch(1),
                         ch(2), top, bottom, lock, tri_ref(k, 3), tri_ref((k + 2) % 12, 3), tri_ref(k, 3),
                         (k == 6), (k == 0), (k == 11));
            end
        end
    endtask

    task automatic test_reset_midop();
        period_in = 6'd5; phase_in = {8'd0, 8'd2, 8'd0}; period_load = 1'b1;
        step();
        period_load = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (triangle !== '0 || top !== 1'b0 || bottom !== 1'b0 || lock !== 1'b0) begin
            errors++; $display("FAIL midreset got tri=%h top=%b bot=%b lock=%b exp zero", triangle, top, bottom, lock);
        end
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 17; k++) begin
            step();
            checks++;
            if (ch(0) !== exp16[k % 16] || ch(1) !== exp16[k % 16] || bottom !== (k % 16 == 0)) begin
                errors++;
                $display("FAIL midreset_run k=%0d got %0d %0d bot=%b exp %0d %0d %b", k, ch(0), ch(1), bottom,
                         exp16[k % 16], exp16[k % 16], (k % 16 == 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_phase();
        test_freeze();
        test_period_change();
        test_zero_period();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
